// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared types and constants for the stochastic decode path
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } sc_state_e;

    // Matches the 8-bit LFSR period used by the generator side.
    localparam int SC_DEFAULT_WINDOW = 255;

    function automatic int sc_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sc_window_counter.sv
// rtl/sc_window_counter.sv - sample counter and ones accumulator with terminal count
module sc_window_counter
    import sc_pkg::*;
#(
    parameter int WINDOW = SC_DEFAULT_WINDOW,
    parameter int CW     = sc_clog2(WINDOW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    input  logic          bit_in,
    output logic [CW-1:0] ones_next,
    output logic          terminal
);

    logic [CW-1:0] sample_cnt;
    logic [CW-1:0] ones;

    // ones_next includes the current sample so the final count is usable on the terminal edge.
    assign ones_next = ones + CW'(bit_in);
    assign terminal  = enable && (sample_cnt == CW'(WINDOW - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sample_cnt <= '0;
            ones       <= '0;
        end else if (enable) begin
            sample_cnt <= sample_cnt + CW'(1);
            ones       <= ones_next;
        end
    end

endmodule

// File: rtl/sc_stream_decoder.sv
// rtl/sc_stream_decoder.sv - stochastic-to-binary decoder; SC_BIPOLAR_EN selects bipolar output
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int WINDOW = SC_DEFAULT_WINDOW,
    parameter int CW     = sc_clog2(WINDOW + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic        busy,
`ifdef SC_BIPOLAR_EN
    output logic signed [CW:0] result,
`else
    output logic [CW-1:0]      result,
`endif
    output logic        result_valid,
    input  logic        result_ready
);

    sc_state_e     state_q;
    sc_state_e     state_d;
    logic          cnt_clear;
    logic          cnt_enable;
    logic          cnt_terminal;
    logic          load_result;
    logic          accept_result;
    logic [CW-1:0] ones_next;

    sc_window_counter #(
        .WINDOW (WINDOW),
        .CW     (CW)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (cnt_clear),
        .enable    (cnt_enable),
        .bit_in    (bit_in),
        .ones_next (ones_next),
        .terminal  (cnt_terminal)
    );

    assign cnt_enable = (state_q == ACCUM) && bit_valid;
    assign busy       = (state_q == ACCUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_clear     = 1'b0;
        load_result   = 1'b0;
        accept_result = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ACCUM;
                    cnt_clear = 1'b1;
                end
            end
            ACCUM: begin
                if (cnt_terminal) begin
                    state_d     = DONE;
                    load_result = 1'b1;
                end
            end
            DONE: begin
                if (result_ready) begin
                    accept_result = 1'b1;
                    // Back-to-back conversion skips IDLE entirely.
                    if (start) begin
                        state_d   = ACCUM;
                        cnt_clear = 1'b1;
                    end else begin
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef SC_BIPOLAR_EN
    // 2*ones - WINDOW always fits CW+1 signed bits, so wrap-around arithmetic is exact.
    logic [CW:0] mapped;
    assign mapped = {ones_next, 1'b0} - (CW + 1)'(WINDOW);
`else
    logic [CW-1:0] mapped;
    assign mapped = ones_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else if (load_result) begin
            result       <= mapped;
            result_valid <= 1'b1;
        end else if (accept_result) begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb/tb_sc_stream_decoder.sv - scoreboard bench for sc_stream_decoder; honours SC_BIPOLAR_EN
module tb_sc_stream_decoder;

    localparam int WIN = 255;
    localparam int CW  = $clog2(WIN + 1);

    typedef struct {
        int value;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, bit_in, bit_valid, result_ready;
    logic busy, result_valid;
    logic w1_start, w1_bit, w1_bvalid, w1_ready, w1_busy, w1_rvalid;
`ifdef SC_BIPOLAR_EN
    logic signed [CW:0] result;
    logic signed [1:0]  w1_result;
`else
    logic [CW-1:0]      result;
    logic [0:0]         w1_result;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sc_stream_decoder #(.WINDOW(WIN)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .busy(busy), .result(result), .result_valid(result_valid), .result_ready(result_ready)
    );

    sc_stream_decoder #(.WINDOW(1)) u_dut_w1 (
        .clk(clk), .rst(rst), .start(w1_start), .bit_in(w1_bit), .bit_valid(w1_bvalid),
        .busy(w1_busy), .result(w1_result), .result_valid(w1_rvalid), .result_ready(w1_ready)
    );

    function automatic int exp_of(input int ones, input int w);
`ifdef SC_BIPOLAR_EN
        return 2 * ones - w;
`else
        return ones;
`endif
    endfunction

    function automatic int res_val();
`ifdef SC_BIPOLAR_EN
        return int'($signed(result));
`else
        return int'(result);
`endif
    endfunction

    function automatic int w1_val();
`ifdef SC_BIPOLAR_EN
        return int'($signed(w1_result));
`else
        return int'(w1_result);
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares results on valid rise, checks hold and acceptance behaviour.
    int prev_valid = 0, prev_ready = 0, prev_start = 0, prev_busy = 0, prev_result = 0;
    int entry_cyc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (busy && !prev_busy) entry_cyc = cyc;
            if (result_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("result", res_val(), e.value);
                    check("latency", cyc - entry_cyc, e.lat);
                    check("busy_low_in_done", int'(busy), 0);
                end
            end else if (prev_valid != 0 && prev_ready == 0) begin
                check("hold_valid", int'(result_valid), 1);
                check("hold_result", res_val(), prev_result);
                check("hold_busy", int'(busy), 0);
            end else if (prev_valid != 0 && prev_ready != 0) begin
                check("ack_valid_clear", int'(result_valid), 0);
                check("ack_result_kept", res_val(), prev_result);
                check("ack_next_busy", int'(busy), prev_start);
            end
        end
        prev_valid  = rst ? 0 : int'(result_valid);
        prev_ready  = int'(result_ready);
        prev_start  = int'(start);
        prev_busy   = rst ? 0 : int'(busy);
        prev_result = res_val();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives samples until `target` valid ones have been sent; k counts cycles after ACCUM entry.
    task automatic feed(input int mode, input int target, output int ones, output int k);
        int nvalid;
        logic v, b;
        nvalid = 0;
        ones = 0;
        k = 0;
        while (nvalid < target) begin
            k++;
            v = 1'b1;
            b = 1'b0;
            start = 1'b0;
            case (mode)
                0: b = 1'b1;
                1: b = 1'b0;
                2: begin
                    if (k % 3 == 0) begin
                        v = 1'b0;
                        b = 1'($urandom_range(0, 1));
                    end else begin
                        b = (nvalid % 2 == 0);
                    end
                end
                3: b = (nvalid < 100);
                default: begin
                    v = ($urandom_range(0, 3) != 0);
                    b = 1'($urandom_range(0, 1));
                    start = ($urandom_range(0, 7) == 0);
                end
            endcase
            bit_valid = v;
            bit_in = b;
            if (v) begin
                nvalid++;
                ones += int'(b);
            end
            tick();
        end
        bit_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic convert(input int mode);
        int ones, k;
        exp_t e;
        feed(mode, WIN, ones, k);
        e.value = exp_of(ones, WIN);
        e.lat = k;
        sb.push_back(e);
    endtask

    task automatic accept(input int delay, input logic b2b);
        int guard;
        guard = 0;
        while (!result_valid && guard < 20) begin
            tick();
            guard++;
        end
        if (!result_valid) check("result_valid_timeout", 0, 1);
        for (int i = 0; i < delay; i++) begin
            start = ($urandom_range(0, 1) != 0);
            tick();
        end
        start = b2b;
        result_ready = 1'b1;
        tick();
        start = 1'b0;
        result_ready = 1'b0;
    endtask

    initial begin
        int ones, k;
        rst = 1'b1; start = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; result_ready = 1'b0;
        w1_start = 1'b0; w1_bit = 1'b0; w1_bvalid = 1'b0; w1_ready = 1'b0;
        repeat (3) tick();
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(result_valid), 0);
        check("reset_result", res_val(), 0);
        start = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'($urandom_range(0, 1));
            bit_in = 1'($urandom_range(0, 1));
            tick();
        end
        bit_valid = 1'b0;
        check("idle_ignores_bits", int'(busy), 0);

        do_start(); convert(0); accept(5, 1'b0);
        do_start(); convert(1); accept(2, 1'b0);
        do_start(); convert(2); accept(0, 1'b0);

        do_start(); convert(4); accept(1, 1'b1);
        check("b2b_busy", int'(busy), 1);
        convert(3); accept(1, 1'b0);

        do_start();
        feed(4, 120, ones, k);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_valid", int'(result_valid), 0);
        check("rst_mid_result", res_val(), 0);
        do_start(); convert(4); accept(3, 1'b0);

        for (int n = 0; n < 4; n++) begin
            do_start();
            convert(4);
            accept($urandom_range(0, 4), 1'($urandom_range(0, 1)));
            if (busy) begin
                convert(4);
                accept(0, 1'b0);
            end
        end

        for (int b = 1; b >= 0; b--) begin
            w1_start = 1'b1;
            tick();
            w1_start = 1'b0;
            tick();
            check("w1_gap_no_result", int'(w1_rvalid), 0);
            w1_bvalid = 1'b1;
            w1_bit = 1'(b);
            tick();
            w1_bvalid = 1'b0;
            check("w1_valid", int'(w1_rvalid), 1);
            check("w1_result", w1_val(), exp_of(b, 1));
            check("w1_busy", int'(w1_busy), 0);
            w1_ready = 1'b1;
            tick();
            w1_ready = 1'b0;
            check("w1_ack", int'(w1_rvalid), 0);
        end

        repeat (3) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
